// File: rtl/i2c_target_regs_if.sv
// i2c_target_regs_if: host register port plus I2C write and busy indications
interface i2c_target_regs_if #(parameter int DEPTH = 16);
  localparam int AW = $clog2(DEPTH);
  logic [AW-1:0] host_addr;
  logic host_we;
  logic [7:0] host_wdata;
  logic [7:0] host_rdata;
  logic wr_strobe;
  logic [AW-1:0] wr_offset;
  logic busy;
  modport master (output host_addr, host_we, host_wdata, input host_rdata, wr_strobe, wr_offset, busy);
  modport slave (input host_addr, host_we, host_wdata, output host_rdata, wr_strobe, wr_offset, busy);
endinterface

// File: rtl/i2c_target_regs.sv
// i2c_target_regs: I2C target exposing DEPTH byte registers to a host port; define I2C_TARGET_GLITCH_FILTER_EN for 3-sample majority filtering of SCL/SDA
module i2c_target_regs #(
  parameter logic [6:0] DEV_ADDR = 7'h23,
  parameter int DEPTH = 16
) (
  input logic SYSTEM_CLK,
  input logic RESET,
  input logic SCL,
  inout wire SDA,
  i2c_target_regs_if.slave hb
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] S_IDLE = 4'd0;
  localparam logic [3:0] S_ADDR = 4'd1;
  localparam logic [3:0] S_ADDR_ACK = 4'd2;
  localparam logic [3:0] S_OFFS = 4'd3;
  localparam logic [3:0] S_OFFS_ACK = 4'd4;
  localparam logic [3:0] S_WDATA = 4'd5;
  localparam logic [3:0] S_WDATA_ACK = 4'd6;
  localparam logic [3:0] S_RDATA = 4'd7;
  localparam logic [3:0] S_RDATA_ACK = 4'd8;
  localparam logic [3:0] S_IGNORE = 4'd9;
  logic [1:0] scl_s, sda_s;
  logic scl, sda, scl_q, sda_q;
  logic start, stop, scl_rise, scl_fall, shift_in, addr_ok, offs_ok;
  logic [3:0] state, cnt;
  logic [7:0] shreg, rdata, rd_byte, rd_next;
  logic [7:0] regs [DEPTH];
  logic [AW-1:0] ptr, wr_off;
  logic sda_oe, rw, m_nack, busy_r, wr_stb;
  // bus synchronizer plus previous-value flops for edge detection; tracks the pins even in reset
  always_ff @(posedge SYSTEM_CLK) begin
    scl_s <= {scl_s[0], SCL};
    sda_s <= {sda_s[0], SDA};
    scl_q <= scl;
    sda_q <= sda;
  end
`ifdef I2C_TARGET_GLITCH_FILTER_EN
  logic [2:0] scl_h, sda_h;
  // three-sample history feeding a majority vote that rejects single-cycle pulses
  always_ff @(posedge SYSTEM_CLK) begin
    scl_h <= {scl_h[1:0], scl_s[1]};
    sda_h <= {sda_h[1:0], sda_s[1]};
  end
  assign scl = (scl_h[0] & scl_h[1]) | (scl_h[0] & scl_h[2]) | (scl_h[1] & scl_h[2]);
  assign sda = (sda_h[0] & sda_h[1]) | (sda_h[0] & sda_h[2]) | (sda_h[1] & sda_h[2]);
`else
  assign scl = scl_s[1];
  assign sda = sda_s[1];
`endif
  assign start = scl & scl_q & sda_q & ~sda;
  assign stop = scl & scl_q & ~sda_q & sda;
  assign scl_rise = scl & ~scl_q;
  assign scl_fall = ~scl & scl_q;
  assign shift_in = scl_rise && (state == S_ADDR || state == S_OFFS || state == S_WDATA);
  assign addr_ok = shreg[7:1] == DEV_ADDR;
  assign offs_ok = {1'b0, shreg} < 9'(DEPTH);
  assign rd_byte = regs[ptr];
  assign rd_next = regs[ptr + AW'(1)];
  assign SDA = sda_oe ? 1'b0 : 1'bz;
  assign hb.host_rdata = rdata;
  assign hb.wr_strobe = wr_stb;
  assign hb.wr_offset = wr_off;
  assign hb.busy = busy_r;
  // protocol FSM and register file in one block so a same-cycle I2C write lands after, and overrides, the host write
  always_ff @(posedge SYSTEM_CLK) begin
    wr_stb <= 1'b0;
    rdata <= regs[hb.host_addr];
    if (hb.host_we) regs[hb.host_addr] <= hb.host_wdata;
    if (RESET) begin
      state <= S_IDLE;
      cnt <= 4'd0;
      shreg <= 8'h00;
      ptr <= '0;
      sda_oe <= 1'b0;
      rw <= 1'b0;
      m_nack <= 1'b0;
      busy_r <= 1'b0;
      wr_off <= '0;
      rdata <= 8'h00;
      for (int i = 0; i < DEPTH; i++) regs[i] <= 8'h00;
    end else if (stop) begin
      state <= S_IDLE;
      sda_oe <= 1'b0;
      busy_r <= 1'b0;
    end else if (start) begin
      state <= S_ADDR;
      cnt <= 4'd0;
      sda_oe <= 1'b0;
    end else begin
      if (scl_rise) cnt <= cnt + 4'd1;
      if (shift_in) shreg <= {shreg[6:0], sda};
      if (scl_rise && state == S_RDATA_ACK) m_nack <= sda;
      if (scl_fall)
        case (state)
          S_ADDR: if (cnt == 4'd8) begin
            cnt <= 4'd0;
            rw <= shreg[0];
            sda_oe <= addr_ok;
            busy_r <= addr_ok;
            state <= addr_ok ? S_ADDR_ACK : S_IGNORE;
          end
          S_ADDR_ACK: begin
            cnt <= 4'd0;
            shreg <= rd_byte;
            sda_oe <= rw & ~rd_byte[7];
            state <= rw ? S_RDATA : S_OFFS;
          end
          S_OFFS: if (cnt == 4'd8) begin
            cnt <= 4'd0;
            if (offs_ok) ptr <= shreg[AW-1:0];
            sda_oe <= offs_ok;
            state <= offs_ok ? S_OFFS_ACK : S_IGNORE;
          end
          S_OFFS_ACK, S_WDATA_ACK: begin
            cnt <= 4'd0;
            sda_oe <= 1'b0;
            state <= S_WDATA;
          end
          S_WDATA: if (cnt == 4'd8) begin
            cnt <= 4'd0;
            regs[ptr] <= shreg;
            wr_stb <= 1'b1;
            wr_off <= ptr;
            ptr <= ptr + AW'(1);
            sda_oe <= 1'b1;
            state <= S_WDATA_ACK;
          end
          S_RDATA: if (cnt == 4'd8) begin
            sda_oe <= 1'b0;
            state <= S_RDATA_ACK;
          end else begin
            shreg <= {shreg[6:0], 1'b0};
            sda_oe <= ~shreg[6];
          end
          S_RDATA_ACK: begin
            cnt <= 4'd0;
            ptr <= m_nack ? ptr : ptr + AW'(1);
            shreg <= rd_next;
            sda_oe <= ~m_nack & ~rd_next[7];
            state <= m_nack ? S_IGNORE : S_RDATA;
          end
          default: sda_oe <= 1'b0;
        endcase
    end
  end
endmodule

// File: tb/tb_i2c_target_regs.sv
// tb_i2c_target_regs: directed I2C master and host-port checks for i2c_target_regs
module tb_i2c_target_regs;
  localparam int Q = 100;
`ifdef I2C_TARGET_GLITCH_FILTER_EN
  localparam int HLAT = 40;
`else
  localparam int HLAT = 20;
`endif
  logic clk = 1'b0, rst = 1'b1, scl = 1'b1, m_low = 1'b0;
  wire sda;
  int vectors = 0, miscompares = 0, n_wr = 0;
  logic [3:0] offs_log [8];
  bit dut_drove = 1'b0, busy_seen = 1'b0;
  logic a;
  logic [7:0] d, ored;
  i2c_target_regs_if #(.DEPTH(16)) hb();
  assign sda = m_low ? 1'b0 : 1'bz;
  pullup (sda);
  always #5 clk = ~clk;
  i2c_target_regs #(.DEV_ADDR(7'h23), .DEPTH(16)) dut (.SYSTEM_CLK(clk), .RESET(rst), .SCL(scl), .SDA(sda), .hb(hb));
  // log write indications, busy, and any SDA low the master did not cause
  always @(negedge clk) begin
    #1;
    if (hb.wr_strobe) begin
      if (n_wr < 8) offs_log[n_wr] = hb.wr_offset;
      n_wr++;
    end
    if (!m_low && sda === 1'b0) dut_drove = 1'b1;
    if (hb.busy) busy_seen = 1'b1;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic i2c_start();
    m_low = 1'b0; #Q;
    scl = 1'b1; #Q;
    m_low = 1'b1; #Q;
    scl = 1'b0; #Q;
  endtask
  task automatic i2c_stop();
    m_low = 1'b1; #Q;
    scl = 1'b1; #Q;
    m_low = 1'b0; #Q;
  endtask
  task automatic wbit(input logic b, input bit hc);
    m_low = ~b; #Q;
    scl = 1'b1; #(2*Q);
    scl = 1'b0;
    if (hc) begin
      #HLAT;
      hb.host_we = 1'b1; #10;
      hb.host_we = 1'b0; #(Q-HLAT-10);
    end else #Q;
  endtask
  task automatic rbit(output logic b);
    m_low = 1'b0; #Q;
    scl = 1'b1; #Q;
    b = (sda === 1'b0) ? 1'b0 : 1'b1; #Q;
    scl = 1'b0; #Q;
  endtask
  task automatic wbyte(input logic [7:0] v, input bit hc, output logic ack);
    for (int i = 7; i >= 0; i--) wbit(v[i], hc && i == 0);
    rbit(ack);
  endtask
  task automatic rbyte(input logic nack, output logic [7:0] v);
    logic b;
    for (int i = 0; i < 8; i++) begin
      rbit(b);
      v = {v[6:0], b};
    end
    wbit(nack, 1'b0);
  endtask
  task automatic hread(input logic [3:0] ad, output logic [7:0] v);
    hb.host_addr = ad; #20;
    v = hb.host_rdata;
  endtask
  task automatic hwrite(input logic [3:0] ad, input logic [7:0] v);
    hb.host_addr = ad;
    hb.host_wdata = v;
    hb.host_we = 1'b1; #10;
    hb.host_we = 1'b0;
  endtask
  initial begin
    hb.host_addr = '0;
    hb.host_we = 1'b0;
    hb.host_wdata = 8'h00;
    #100;
    rst = 1'b0;
    #100;
    chk("rst_sda", sda, 1);
    chk("rst_busy", hb.busy, 0);
    chk("rst_wr_strobe", hb.wr_strobe, 0);
    chk("rst_wr_offset", hb.wr_offset, 0);
    hread(4'd5, d);
    chk("rst_rdata", d, 8'h00);
    n_wr = 0;
    i2c_start();
    wbyte(8'h46, 1'b0, a); chk("w_ack_addr", a, 0);
    wbyte(8'h05, 1'b0, a); chk("w_ack_offs", a, 0);
    wbyte(8'hA5, 1'b0, a); chk("w_ack_d0", a, 0);
    wbyte(8'h3C, 1'b0, a); chk("w_ack_d1", a, 0);
    chk("w_busy", hb.busy, 1);
    i2c_stop();
    chk("w_busy_stop", hb.busy, 0);
    chk("w_nstrobe", n_wr, 2);
    chk("w_off0", offs_log[0], 5);
    chk("w_off1", offs_log[1], 6);
    hread(4'd5, d); chk("w_reg5", d, 8'hA5);
    hread(4'd6, d); chk("w_reg6", d, 8'h3C);
    i2c_start();
    wbyte(8'h46, 1'b0, a);
    wbyte(8'h05, 1'b0, a);
    i2c_start();
    wbyte(8'h47, 1'b0, a); chk("r_ack_addr", a, 0);
    rbyte(1'b0, d); chk("r_byte0", d, 8'hA5);
    rbyte(1'b1, d); chk("r_byte1", d, 8'h3C);
    m_low = 1'b0; #Q;
    chk("r_released", sda, 1);
    chk("r_busy", hb.busy, 1);
    i2c_stop();
    chk("r_busy_stop", hb.busy, 0);
    dut_drove = 1'b0;
    busy_seen = 1'b0;
    i2c_start();
    wbyte(8'h48, 1'b0, a); chk("x_nack_addr", a, 1);
    wbyte(8'h00, 1'b0, a); chk("x_nack_data", a, 1);
    i2c_stop();
    #Q;
    chk("x_no_drive", dut_drove, 0);
    chk("x_no_busy", busy_seen, 0);
    n_wr = 0;
    i2c_start();
    wbyte(8'h46, 1'b0, a);
    wbyte(8'h0F, 1'b0, a); chk("wrap_ack_offs", a, 0);
    wbyte(8'h11, 1'b0, a);
    wbyte(8'h22, 1'b0, a);
    i2c_stop();
    chk("wrap_off0", offs_log[0], 15);
    chk("wrap_off1", offs_log[1], 0);
    hread(4'd15, d); chk("wrap_reg15", d, 8'h11);
    hread(4'd0, d); chk("wrap_reg0", d, 8'h22);
    i2c_start();
    wbyte(8'h46, 1'b0, a); chk("big_ack_addr", a, 0);
    wbyte(8'h10, 1'b0, a); chk("big_nack_offs", a, 1);
    wbyte(8'h55, 1'b0, a); chk("big_nack_data", a, 1);
    i2c_stop();
    chk("big_nstrobe", n_wr, 2);
    n_wr = 0;
    i2c_start();
    wbyte(8'h46, 1'b0, a);
    wbyte(8'h07, 1'b0, a);
    for (int i = 0; i < 4; i++) wbit(1'b1, 1'b0);
    i2c_start();
    i2c_stop();
    chk("abort_nstrobe", n_wr, 0);
    hread(4'd7, d); chk("abort_reg7", d, 8'h00);
    i2c_start();
    wbyte(8'h46, 1'b0, a);
    wbyte(8'h03, 1'b0, a);
    hb.host_addr = 4'd3;
    hb.host_wdata = 8'hEE;
    wbyte(8'h5A, 1'b1, a);
    hb.host_addr = 4'd9;
    hb.host_wdata = 8'h99;
    wbyte(8'h77, 1'b1, a);
    i2c_stop();
    hread(4'd3, d); chk("col_reg3", d, 8'h5A);
    hread(4'd4, d); chk("col_reg4", d, 8'h77);
    hread(4'd9, d); chk("col_reg9", d, 8'h99);
    hwrite(4'd0, 8'h00);
    i2c_start();
    wbyte(8'h46, 1'b0, a);
    wbyte(8'h00, 1'b0, a);
    i2c_start();
    wbyte(8'h47, 1'b0, a); chk("mr_ack_addr", a, 0);
    for (int i = 0; i < 3; i++) rbit(a);
    m_low = 1'b0; #Q;
    scl = 1'b1; #Q;
    chk("mr_driving", sda, 0);
    rst = 1'b1; #10;
    chk("mr_released", sda, 1);
    rst = 1'b0; #(Q-10);
    scl = 1'b0; #Q;
    i2c_stop();
    chk("mr_busy", hb.busy, 0);
    ored = 8'h00;
    for (int i = 0; i < 16; i++) begin
      hread(4'(i), d);
      ored = ored | d;
    end
    chk("mr_regs_zero", ored, 8'h00);
    i2c_start();
    wbyte(8'h46, 1'b0, a); chk("mr_post_ack_addr", a, 0);
    wbyte(8'h02, 1'b0, a); chk("mr_post_ack_offs", a, 0);
    wbyte(8'hC3, 1'b0, a); chk("mr_post_ack_data", a, 0);
    i2c_stop();
    hread(4'd2, d); chk("mr_post_reg2", d, 8'hC3);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/i2c_target_regs.md
I2C_TARGET_REGS -- requirements
Module: i2c_target_regs

Interface
REQ-001 Parameter DEV_ADDR, default 7'h23, 7-bit target address (8'h46 write / 8'h47 read on the bus).
REQ-002 Parameter DEPTH, default 16, number of 8-bit registers; power of two, 2..256.
REQ-003 SYSTEM_CLK  input  1  sole clock; all logic on its rising edge.
REQ-004 RESET  input  1  synchronous, active-high reset.
REQ-005 SCL  input  1  I2C clock from the master; the block never drives it.
REQ-006 SDA  inout  1  I2C data, open-drain: driven 0 or Z only, never 1.
REQ-007 host_addr  input  log2(DEPTH)  host-side register index for read and write.
REQ-008 host_we  input  1  host write strobe; writes host_wdata into host_addr.
REQ-009 host_wdata  input  8  host write data.
REQ-010 host_rdata  output  8  registered content of host_addr, 1-cycle latency.
REQ-011 wr_strobe  output  1  1-cycle pulse per register written over I2C.
REQ-012 wr_offset  output  log2(DEPTH)  index written, valid with wr_strobe.
REQ-013 busy  output  1  high from addressed START to STOP or NACKed address.

Function
REQ-014 SCL/SDA pass through a 2-flop synchronizer; edges are detected on the synchronized values.
REQ-015 START: SDA falls while SCL is high. STOP: SDA rises while SCL is high. Both act from any state.
REQ-016 States: IDLE, ADDR, ADDR_ACK, OFFS, OFFS_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
REQ-017 Bits are sampled on SCL rise, MSB first; SDA drive changes only on synchronized SCL fall.
REQ-018 ADDR: after 8 bits, match of bits[7:1] to DEV_ADDR -> ADDR_ACK (drive 0 for one SCL period); mismatch -> IGNORE, no drive.
REQ-019 R/W=0 -> OFFS; offset < DEPTH is ACKed and loads the pointer; offset >= DEPTH is NACKed -> IGNORE.
REQ-020 WDATA: each byte is ACKed, written to reg[pointer], pulses wr_strobe/wr_offset, pointer increments modulo DEPTH.
REQ-021 R/W=1 -> RDATA: reg[pointer] loaded into shift register at ACK end; first bit driven on the following SCL fall.
REQ-022 RDATA_ACK: master ACK -> pointer+1 modulo DEPTH, next byte; master NACK -> IGNORE, SDA released.
REQ-023 Repeated START returns to ADDR and keeps the pointer, so write-offset then Sr read works.
REQ-024 STOP -> IDLE, SDA released, busy low, pointer retained.
REQ-025 IGNORE releases SDA and waits for START or STOP.
REQ-026 Same-cycle I2C write and host_we to the same index: the I2C write wins; different indices: both complete.
REQ-027 START during a byte aborts the byte; the partial byte is discarded and no register is written.

Reset
REQ-028 RESET forces IDLE, SDA released (Z), busy=0, wr_strobe=0, wr_offset=0, pointer=0, host_rdata=0, all registers=8'h00.
REQ-029 RESET asserted mid-transfer releases SDA on the next clock edge; the block ignores the bus until the next START.

Configuration
REQ-030 Macro I2C_TARGET_GLITCH_FILTER_EN defined: synchronized SCL/SDA each pass a 3-sample majority filter (+2 cycles latency); single-cycle pulses are rejected.
REQ-031 Macro undefined: no filter; synchronizer output is used directly; every other requirement is unchanged.

Verification
REQ-032 Master writes 46,05,A5,3C, then STOP -> ACK on all four bytes; reg5=A5, reg6=3C; two wr_strobe pulses with wr_offset 5, 6.
REQ-033 Master sends 46,05, then Sr, then 47, reads 2 bytes (ACK, then NACK) -> SDA carries A5, 3C; after the NACK, SDA is released.
REQ-034 Master sends 48 (wrong address) -> NACK; SDA stays Z through STOP; busy stays 0.
REQ-035 Master writes 46,0F,11,22 (DEPTH=16) -> reg15=11, reg0=22 (wrap); offset 10h is NACKed.
REQ-036 I2C write to reg3 and host_we to reg3 in the same cycle -> reg3 holds the I2C value; host_rdata shows it one cycle later.
REQ-037 RESET pulsed during the RDATA bit 4 -> SDA is Z the next cycle, all registers 00, the next 46 transaction succeeds.
